// File: rtl/writeback_arbiter.sv
// writeback_arbiter: buffers completed results from N_CH execute channels in
// per-channel FIFOs and retires up to two per cycle, one to the integer
// register file and one to the FP register file, each chosen round-robin.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous discard of all buffered entries
//   in_valid/in_ready per-channel push handshake (in_ready is combinational)
//   in_rd, in_data, in_is_freg, in_no_write, in_is_jump, in_next_pc
//                     per-channel result fields, packed channel-major
//   reg_w_*           registered integer register-file write port
//   freg_w_*          registered FP register-file write port
//   retire_cnt        registered number of entries retired (0..2)
//   jump_valid/pc     registered PC redirect from a retired INT jump
module writeback_arbiter #(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic [N_CH*5-1:0]      in_rd,
    input  logic [N_CH*XLEN-1:0]   in_data,
    input  logic [N_CH-1:0]        in_is_freg,
    input  logic [N_CH-1:0]        in_no_write,
    input  logic [N_CH-1:0]        in_is_jump,
    input  logic [N_CH*XLEN-1:0]   in_next_pc,
    output logic                   reg_w_enable,
    output logic [4:0]             reg_w_dest,
    output logic [XLEN-1:0]        reg_w_data,
    output logic                   freg_w_enable,
    output logic [4:0]             freg_w_dest,
    output logic [XLEN-1:0]        freg_w_data,
    output logic [1:0]             retire_cnt,
    output logic                   jump_valid,
    output logic [XLEN-1:0]        jump_pc
);

    localparam int unsigned RW    = 5;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned CW    = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Per-channel FIFO storage
    logic [RW-1:0]    r_rd    [N_CH][DEPTH];
    logic [XLEN-1:0]  r_data  [N_CH][DEPTH];
    logic             r_freg  [N_CH][DEPTH];
    logic             r_nowr  [N_CH][DEPTH];
    logic             r_jump  [N_CH][DEPTH];
    logic [XLEN-1:0]  r_npc   [N_CH][DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [PTR_W-1:0] r_wptr  [N_CH];
    logic [PTR_W-1:0] r_rptr  [N_CH];

    logic [CW-1:0]    r_int_ptr;
    logic [CW-1:0]    r_fp_ptr;

    logic [N_CH-1:0]  w_empty;
    logic [N_CH-1:0]  w_full;
    logic [N_CH-1:0]  w_int_req;
    logic [N_CH-1:0]  w_fp_req;
    logic [N_CH-1:0]  w_push;
    logic [N_CH-1:0]  w_pop;
    logic [AW-1:0]    w_ridx  [N_CH];
    logic [AW-1:0]    w_widx  [N_CH];

    logic             w_arb_en;
    logic             w_int_any;
    logic [CW-1:0]    w_int_idx;
    logic             w_fp_any;
    logic [CW-1:0]    w_fp_idx;

    logic [AW-1:0]    w_int_slot;
    logic [AW-1:0]    w_fp_slot;
    logic [RW-1:0]    w_int_rd;
    logic [XLEN-1:0]  w_int_data;
    logic             w_int_nowr;
    logic             w_int_jump;
    logic [XLEN-1:0]  w_int_npc;
    logic [RW-1:0]    w_fp_rd;
    logic [XLEN-1:0]  w_fp_data;
    logic             w_reg_we;
    logic             w_jump;

    // FIFO occupancy and head classification
    always_comb begin : p_fifo_status
        for (int i = 0; i < N_CH; i++) begin
            w_empty[i]   = (r_wptr[i] == r_rptr[i]);
            w_full[i]    = ((r_wptr[i] - r_rptr[i]) == PTR_W'(DEPTH));
            w_ridx[i]    = r_rptr[i][AW-1:0];
            w_widx[i]    = r_wptr[i][AW-1:0];
            w_int_req[i] = !w_empty[i] && !r_freg[i][w_ridx[i]];
            w_fp_req[i]  = !w_empty[i] &&  r_freg[i][w_ridx[i]];
        end
    end

    // Ready reflects pre-pop occupancy only, keeping arbitration off this path
    assign in_ready = ~w_full & {N_CH{!rst && !flush}};
    assign w_push   = in_valid & in_ready;
    assign w_arb_en = !rst && !flush;

    // INT round-robin: first requesting channel starting at r_int_ptr
    always_comb begin : p_int_arb
        int unsigned c;
        logic [CW-1:0] ci;
        c         = 0;
        ci        = '0;
        w_int_any = 1'b0;
        w_int_idx = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            c  = (32'(r_int_ptr) + k) % N_CH;
            ci = CW'(c);
            if (w_arb_en && !w_int_any && w_int_req[ci]) begin
                w_int_any = 1'b1;
                w_int_idx = ci;
            end
        end
    end

    // FP round-robin: first requesting channel starting at r_fp_ptr
    always_comb begin : p_fp_arb
        int unsigned c;
        logic [CW-1:0] ci;
        c        = 0;
        ci       = '0;
        w_fp_any = 1'b0;
        w_fp_idx = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            c  = (32'(r_fp_ptr) + k) % N_CH;
            ci = CW'(c);
            if (w_arb_en && !w_fp_any && w_fp_req[ci]) begin
                w_fp_any = 1'b1;
                w_fp_idx = ci;
            end
        end
    end

    // A head is INT or FP, never both, so at most one path pops a channel
    always_comb begin : p_pop
        for (int i = 0; i < N_CH; i++) begin
            w_pop[i] = (w_int_any && (w_int_idx == CW'(i))) ||
                       (w_fp_any  && (w_fp_idx  == CW'(i)));
        end
    end

    // Winner head fields
    assign w_int_slot = w_ridx[w_int_idx];
    assign w_fp_slot  = w_ridx[w_fp_idx];
    assign w_int_rd   = r_rd  [w_int_idx][w_int_slot];
    assign w_int_data = r_data[w_int_idx][w_int_slot];
    assign w_int_nowr = r_nowr[w_int_idx][w_int_slot];
    assign w_int_jump = r_jump[w_int_idx][w_int_slot];
    assign w_int_npc  = r_npc [w_int_idx][w_int_slot];
    assign w_fp_rd    = r_rd  [w_fp_idx][w_fp_slot];
    assign w_fp_data  = r_data[w_fp_idx][w_fp_slot];

    // x0 and no_write entries still retire, they just do not write
    assign w_reg_we = w_int_any && !w_int_nowr && (w_int_rd != '0);
    assign w_jump   = w_int_any && w_int_jump;

    // FIFO payload write; storage needs no reset since pointers gate validity
    always_ff @(posedge clk) begin : p_fifo_mem
        for (int i = 0; i < N_CH; i++) begin
            if (w_push[i]) begin
                r_rd  [i][w_widx[i]] <= in_rd     [i*RW   +: RW];
                r_data[i][w_widx[i]] <= in_data   [i*XLEN +: XLEN];
                r_freg[i][w_widx[i]] <= in_is_freg[i];
                r_nowr[i][w_widx[i]] <= in_no_write[i];
                r_jump[i][w_widx[i]] <= in_is_jump[i];
                r_npc [i][w_widx[i]] <= in_next_pc[i*XLEN +: XLEN];
            end
        end
    end

    // FIFO pointers; flush empties every FIFO at the edge
    always_ff @(posedge clk) begin : p_fifo_ptr
        for (int i = 0; i < N_CH; i++) begin
            if (rst || flush) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end else begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
            end
        end
    end

    // Round-robin pointers survive flush; only reset clears them
    always_ff @(posedge clk) begin : p_rr_ptr
        if (rst) begin
            r_int_ptr <= '0;
            r_fp_ptr  <= '0;
        end else begin
            if (w_int_any)
                r_int_ptr <= (w_int_idx == CW'(N_CH - 1)) ? '0 : w_int_idx + 1'b1;
            if (w_fp_any)
                r_fp_ptr  <= (w_fp_idx  == CW'(N_CH - 1)) ? '0 : w_fp_idx + 1'b1;
        end
    end

    // Registered write ports and control outputs; dest/data/pc hold when idle
    always_ff @(posedge clk) begin : p_outputs
        if (rst) begin
            reg_w_enable  <= 1'b0;
            reg_w_dest    <= '0;
            reg_w_data    <= '0;
            freg_w_enable <= 1'b0;
            freg_w_dest   <= '0;
            freg_w_data   <= '0;
            retire_cnt    <= '0;
            jump_valid    <= 1'b0;
            jump_pc       <= '0;
        end else begin
            reg_w_enable  <= w_reg_we;
            freg_w_enable <= w_fp_any;
            retire_cnt    <= 2'(w_int_any) + 2'(w_fp_any);
            jump_valid    <= w_jump;
            if (w_reg_we) begin
                reg_w_dest <= w_int_rd;
                reg_w_data <= w_int_data;
            end
            if (w_fp_any) begin
                freg_w_dest <= w_fp_rd;
                freg_w_data <= w_fp_data;
            end
            if (w_jump)
                jump_pc <= w_int_npc;
        end
    end

endmodule
